// File: rtl/ann_pkg.sv
// Shared constants and FSM encoding for the layer sequencer and the output Buffer.
package ann_pkg;

   // Width of every read address (input memory and Buffer share it).
   localparam int ADDR_W = 7;

   // Entries per Buffer bank; one entry per neuron.
   localparam int BANK_SIZE = 10;

   // Read address at which the Buffer returns the constant bias value 127.
   localparam logic [ADDR_W-1:0] BIAS_ADDR = 7'd62;

   // Sequencer states; the encoding is also visible on the debug state output.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      DRAIN = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/layer_sequencer.sv
// Layer-by-layer controller for the neuron array and its two-bank output Buffer.
// Each layer issues L data addresses plus the bias address, waits for the neuron
// pipeline to settle, then writes the layer's outputs into bank layer[0].
//
// Handshake: start is a level sampled only in IDLE; no ready is returned. busy
// covers ISSUE/DRAIN/WRITE and done is a single-cycle pulse in DONE. start seen
// in any state other than IDLE is ignored.
module layer_sequencer
   import ann_pkg::*;
#(
   parameter int NUM_LAYERS = 3,
   parameter int IN0_LEN    = 62,
   parameter int NEURONS    = BANK_SIZE,
   parameter int NEURON_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] readloc,
   output logic              src_sel,
   output logic              mac_clr,
   output logic              mac_en,
   output logic [1:0]        layer,
   output logic              write,
   output logic              writeloc,
   output logic              result_bank,
   output logic [2:0]        state_dbg
);

   localparam logic [ADDR_W-1:0] IN0_LEN_A   = ADDR_W'(IN0_LEN);
   localparam logic [ADDR_W-1:0] NEURONS_A   = ADDR_W'(NEURONS);
   localparam logic [2:0]        DRAIN_LAST  = 3'(NEURON_LAT);
   localparam logic [1:0]        LAST_LAYER  = 2'(NUM_LAYERS - 1);
   localparam logic              RESULT_BANK = LAST_LAYER[0];

   // Counters are sized without wrap headroom, so bad parameters must stop elaboration.
   if (NUM_LAYERS < 1 || NUM_LAYERS > 4) begin : g_bad_num_layers
      $error("NUM_LAYERS must be 1..4");
   end
   if (IN0_LEN < 1 || IN0_LEN > 62) begin : g_bad_in0_len
      $error("IN0_LEN must be 1..62");
   end
   if (NEURONS < 1 || 2 * NEURONS > 62) begin : g_bad_neurons
      $error("NEURONS must fit two banks below the bias address");
   end
   if (NEURON_LAT < 0 || NEURON_LAT > 7) begin : g_bad_lat
      $error("NEURON_LAT must be 0..7");
   end

   state_t            state;
   state_t            state_n;
   logic [ADDR_W-1:0] issue_cnt;
   logic [2:0]        drain_cnt;
   logic [1:0]        layer_q;
   logic              mac_en_q;
   logic [ADDR_W-1:0] issue_len;
   logic              issue_last;
   logic [ADDR_W-1:0] prev_base;
   logic [ADDR_W-1:0] data_addr;

   // Address generation: layer 0 walks the input memory, later layers walk the
   // bank written by the previous layer (bank (layer-1)&1, i.e. not layer[0]).
   assign issue_len  = (layer_q == 2'd0) ? IN0_LEN_A : NEURONS_A;
   assign issue_last = (issue_cnt == issue_len);
   assign prev_base  = layer_q[0] ? '0 : NEURONS_A;
   assign data_addr  = (layer_q == 2'd0) ? issue_cnt : prev_base + issue_cnt;

   assign layer       = layer_q;
   assign mac_en      = mac_en_q;
   assign result_bank = RESULT_BANK;
   assign state_dbg   = state;

   // State register, issue/drain counters, layer index and the delayed MAC enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         issue_cnt <= '0;
         drain_cnt <= '0;
         layer_q   <= '0;
         mac_en_q  <= 1'b0;
      end else begin
         state    <= state_n;
         // The Buffer answers one cycle after an address, so the MAC follows ISSUE by one.
         mac_en_q <= (state == ISSUE);

         if (state == ISSUE && !issue_last) begin
            issue_cnt <= issue_cnt + 7'd1;
         end else begin
            issue_cnt <= '0;
         end

         if (state == DRAIN) begin
            drain_cnt <= drain_cnt + 3'd1;
         end else begin
            drain_cnt <= '0;
         end

         if (state == WRITE && layer_q != LAST_LAYER) begin
            layer_q <= layer_q + 2'd1;
         end else if (state == DONE) begin
            layer_q <= '0;
         end
      end
   end

   // Next-state decode and per-state output drive.
   always_comb begin
      state_n  = state;
      busy     = 1'b0;
      done     = 1'b0;
      readloc  = '0;
      src_sel  = 1'b0;
      mac_clr  = 1'b0;
      write    = 1'b0;
      writeloc = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               state_n = ISSUE;
            end
         end
         ISSUE: begin
            busy    = 1'b1;
            src_sel = (layer_q != 2'd0);
            mac_clr = (issue_cnt == '0);
            readloc = issue_last ? BIAS_ADDR : data_addr;
            if (issue_last) begin
               state_n = DRAIN;
            end
         end
         DRAIN: begin
            busy    = 1'b1;
            src_sel = (layer_q != 2'd0);
            readloc = BIAS_ADDR;
            if (drain_cnt == DRAIN_LAST) begin
               state_n = WRITE;
            end
         end
         WRITE: begin
            busy     = 1'b1;
            src_sel  = (layer_q != 2'd0);
            readloc  = BIAS_ADDR;
            write    = 1'b1;
            writeloc = layer_q[0];
            state_n  = (layer_q == LAST_LAYER) ? DONE : ISSUE;
         end
         DONE: begin
            done    = 1'b1;
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule
